// File: rtl/qr_pkg.sv
// Shared constants and FSM state type for the QR bitmap loader.
package qr_pkg;
  localparam int unsigned QR_SIZE       = 27;
  localparam int unsigned BYTES_PER_ROW = 4;
  localparam int unsigned ROW_W         = 5;
  localparam logic [7:0]  SYNC_BYTE     = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StRow,
    StCsum,
    StCheck,
    StPending
  } state_e;
endpackage

// File: rtl/qr_bank_ram.sv
// Two-bank row memory: one write port, one registered read port.
// The array has no reset, so it can map to block RAM.
module qr_bank_ram #(
  parameter int unsigned QR_SIZE = 27
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic                      wr_bank,
  input  logic [qr_pkg::ROW_W-1:0]  wr_row,
  input  logic [QR_SIZE-1:0]        wr_data,
  input  logic                      rd_bank,
  input  logic [qr_pkg::ROW_W-1:0]  rd_row,
  output logic [QR_SIZE-1:0]        rd_data
);

  logic [QR_SIZE-1:0] mem [2][QR_SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_row] <= wr_data;
    end
  end

  // Out-of-range rows read as blank so the VGA stage can scan past the bitmap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (32'(rd_row) < QR_SIZE) begin
      rd_data <= mem[rd_bank][rd_row];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/qr_bitmap_loader.sv
// Receives a framed QR bitmap byte stream, checks it and swaps it into the
// displayed bank at the next frame boundary.
module qr_bitmap_loader #(
  parameter int unsigned QR_SIZE       = qr_pkg::QR_SIZE,
  parameter int unsigned BYTES_PER_ROW = qr_pkg::BYTES_PER_ROW,
  parameter int unsigned TIMEOUT       = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               frame_start,
  input  logic [4:0]         rd_row,
  output logic [QR_SIZE-1:0] rd_data,
  output logic               bank,
  output logic               frame_ok,
  output logic               frame_err,
  output logic               busy
);
  import qr_pkg::*;

  localparam int unsigned PackW = 8 * (BYTES_PER_ROW - 1);
  localparam int unsigned ByteW = $clog2(BYTES_PER_ROW);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ByteW-1:0]   byte_q, byte_d;
  logic [PackW-1:0]   pack_q, pack_d;
  logic [7:0]         acc_q, acc_d;
  logic [IdleW-1:0]   idle_q, idle_d;
  logic               match_q, match_d;
  logic               bank_q, bank_d;

  logic               accept;
  logic               last_byte;
  logic               last_row;
  logic               timed_out;
  logic               we;
  logic [QR_SIZE-1:0] wr_data;

  assign bank      = bank_q;
  assign accept    = in_valid && in_ready;
  assign last_byte = (byte_q == ByteW'(BYTES_PER_ROW - 1));
  assign last_row  = (row_q == ROW_W'(QR_SIZE - 1));
  assign timed_out = (idle_q == IdleW'(TIMEOUT - 1));
  // Earlier bytes sit in pack_q; the final byte completes the row, top bits dropped.
  assign wr_data   = QR_SIZE'({in_data, pack_q});

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    byte_d    = byte_q;
    pack_d    = pack_q;
    acc_d     = acc_q;
    idle_d    = idle_q;
    match_d   = match_q;
    bank_d    = bank_q;
    we        = 1'b0;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept && in_data == SYNC_BYTE) begin
          state_d = StRow;
          row_d   = '0;
          byte_d  = '0;
          acc_d   = '0;
          idle_d  = '0;
        end
      end
      StRow: begin
        in_ready = 1'b1;
        if (accept) begin
          idle_d = '0;
          acc_d  = acc_q ^ in_data;
          pack_d = PackW'({in_data, pack_q} >> 8);
          if (last_byte) begin
            we     = 1'b1;
            byte_d = '0;
            row_d  = row_q + 1'b1;
            if (last_row) begin
              state_d = StCsum;
            end
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end else if (timed_out) begin
          frame_err = 1'b1;
          state_d   = StIdle;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      StCsum: begin
        in_ready = 1'b1;
        if (accept) begin
          idle_d  = '0;
          match_d = (in_data == acc_q);
          state_d = StCheck;
        end else if (timed_out) begin
          frame_err = 1'b1;
          state_d   = StIdle;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      StCheck: begin
        frame_ok  = match_q;
        frame_err = !match_q;
        state_d   = match_q ? StPending : StIdle;
      end
      StPending: begin
        if (frame_start) begin
          bank_d  = ~bank_q;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      byte_q  <= '0;
      pack_q  <= '0;
      acc_q   <= '0;
      idle_q  <= '0;
      match_q <= 1'b0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      byte_q  <= byte_d;
      pack_q  <= pack_d;
      acc_q   <= acc_d;
      idle_q  <= idle_d;
      match_q <= match_d;
      bank_q  <= bank_d;
    end
  end

  qr_bank_ram #(
    .QR_SIZE (QR_SIZE)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_bank (~bank_q),
    .wr_row  (row_q),
    .wr_data (wr_data),
    .rd_bank (bank_q),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_qr_bitmap_loader.sv
// Directed bench for qr_bitmap_loader with a short timeout.
module tb_qr_bitmap_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        frame_start;
  logic [4:0]  rd_row;
  logic [26:0] rd_data;
  logic        bank;
  logic        frame_ok;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0;
  int err_cnt = 0;

  qr_bitmap_loader #(
    .QR_SIZE       (27),
    .BYTES_PER_ROW (4),
    .TIMEOUT       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame_start (frame_start),
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .bank        (bank),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_ok === 1'b1) ok_cnt <= ok_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Pattern A: every row FF FF FF 07. Pattern B: row r is r, 5A, C3, F8.
  task automatic send_row(input bit pat_b, input int r);
    logic [7:0] rb;
    rb = 8'(r);
    if (pat_b) begin
      send_byte(rb); send_byte(8'h5A); send_byte(8'hC3); send_byte(8'hF8);
    end else begin
      send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h07);
    end
  endtask

  task automatic send_frame(input bit pat_b, input logic [7:0] csum);
    send_byte(8'hA5);
    for (int r = 0; r < 27; r++) send_row(pat_b, r);
    send_byte(csum);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; frame_start = 1'b0; rd_row = 5'd0;
    step(); step();
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bank", 32'(bank), 32'h0);
    check("rst_ok", 32'(frame_ok), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    step();
    check("idle_ready", 32'(in_ready), 32'h1);

    // Garbage before sync, then a good all-ones frame.
    send_byte(8'h00);
    send_byte(8'h5A);
    check("garbage_idle", 32'(busy), 32'h0);
    send_frame(1'b0, 8'hF8);
    check("a_ok", 32'(frame_ok), 32'h1);
    check("a_err", 32'(frame_err), 32'h0);
    check("a_check_ready", 32'(in_ready), 32'h0);

    // Back-pressure in PENDING with a byte held valid.
    in_data = 8'h00; in_valid = 1'b1; rd_row = 5'd5;
    step();
    check("a_pend_busy", 32'(busy), 32'h1);
    check("a_ok_once", 32'(ok_cnt), 32'd1);
    check("a_ok_low", 32'(frame_ok), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ready", 32'(in_ready), 32'h0);
      check("bp_bank", 32'(bank), 32'h0);
    end
    pulse_frame_start();
    check("a_bank_swap", 32'(bank), 32'h1);
    check("a_ready_after", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    check("a_row5", 32'(rd_data), 32'h07FF_FFFF);
    check("a_idle", 32'(busy), 32'h0);

    // frame_start in IDLE is ignored.
    pulse_frame_start();
    check("idle_fs", 32'(bank), 32'h1);

    // Pattern B; frame_start during CHECK is ignored.
    send_frame(1'b1, 8'h7A);
    check("b_ok", 32'(frame_ok), 32'h1);
    pulse_frame_start();
    check("b_fs_check_bank", 32'(bank), 32'h1);
    check("b_fs_check_busy", 32'(busy), 32'h1);
    step();
    pulse_frame_start();
    check("b_bank_swap", 32'(bank), 32'h0);
    rd_row = 5'd3;  step(); check("b_row3", 32'(rd_data), 32'h00C3_5A03);
    rd_row = 5'd26; step(); check("b_row26", 32'(rd_data), 32'h00C3_5A1A);
    rd_row = 5'd27; step(); check("b_row27", 32'(rd_data), 32'h0);
    rd_row = 5'd31; step(); check("b_row31", 32'(rd_data), 32'h0);

    // Corrupt checksum.
    rd_row = 5'd26;
    send_frame(1'b0, 8'hF9);
    check("c_err", 32'(frame_err), 32'h1);
    check("c_ok", 32'(frame_ok), 32'h0);
    step();
    check("c_idle", 32'(busy), 32'h0);
    check("c_ready", 32'(in_ready), 32'h1);
    check("c_bank", 32'(bank), 32'h0);
    check("c_rd_data", 32'(rd_data), 32'h00C3_5A1A);

    // Timeout after 10 payload bytes.
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_byte(8'hFF);
    for (int i = 1; i < 16; i++) begin
      check("to_quiet", 32'(frame_err), 32'h0);
      step();
    end
    check("to_err", 32'(frame_err), 32'h1);
    check("to_busy", 32'(busy), 32'h1);
    step();
    check("to_idle", 32'(busy), 32'h0);
    check("to_err_low", 32'(frame_err), 32'h0);
    send_frame(1'b0, 8'hF8);
    check("to_reload_ok", 32'(frame_ok), 32'h1);
    step();
    pulse_frame_start();
    check("to_bank", 32'(bank), 32'h1);
    rd_row = 5'd5;
    step();
    check("to_row5", 32'(rd_data), 32'h07FF_FFFF);

    // Asynchronous reset in the middle of row 12.
    send_byte(8'hA5);
    for (int r = 0; r < 12; r++) send_row(1'b0, r);
    send_byte(8'hFF);
    send_byte(8'hFF);
    #2 rst = 1'b1;
    #1;
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_bank", 32'(bank), 32'h0);
    check("mr_rd_data", 32'(rd_data), 32'h0);
    check("mr_ready", 32'(in_ready), 32'h1);
    step(); step();
    rst = 1'b0;
    step();
    send_frame(1'b1, 8'h7A);
    check("mr_ok", 32'(frame_ok), 32'h1);
    step();
    pulse_frame_start();
    check("mr_bank_swap", 32'(bank), 32'h1);
    rd_row = 5'd7;
    step();
    check("mr_row7", 32'(rd_data), 32'h00C3_5A07);

    check("ok_total", 32'(ok_cnt), 32'd4);
    check("err_total", 32'(err_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
